// File: rtl/oam_dma_arbiter.sv
// OAM DMA engine and CPU/DMA bus arbiter: copies DMA_LEN bytes from page {src,00} to OAM_BASE.
// Build option DMA_CPU_BLOCK_EN: non-HRAM CPU accesses are blocked during DMA instead of stealing.
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter logic [15:0] OAM_BASE     = 16'hFE00,
  parameter int unsigned DMA_LEN      = 160
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic        dma_active
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StRead  = 2'd2;
  localparam logic [1:0] StWrite = 2'd3;

  localparam logic [8:0] LenCount = 9'(DMA_LEN);

  logic [1:0] state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] latch_q, latch_d;
  logic [7:0] src_page_q, src_page_d;

  logic       reg_hit, reg_wr, reg_rd, cpu_acc, active, cpu_wins;
  logic       dma_rd, dma_wr;
  logic [7:0] rd_page;

  assign reg_hit = (cpu_addr == DMA_REG_ADDR);
  assign reg_wr  = cpu_we & reg_hit;
  assign reg_rd  = cpu_re & reg_hit;
  assign cpu_acc = (cpu_we | cpu_re) & ~reg_hit;
  assign active  = (state_q != StIdle);

`ifdef DMA_CPU_BLOCK_EN
  logic hram_hit;
  assign hram_hit = (cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE);
  assign cpu_wins = cpu_acc & (~active | hram_hit);
`else
  assign cpu_wins = cpu_acc;
`endif

  // A register write restarts the engine, so that cycle carries no DMA bus step.
  assign dma_rd = (state_q == StRead) & ~cpu_wins & ~reg_wr & ~reset;
  assign dma_wr = (state_q == StWrite) & ~cpu_wins & ~reg_wr & ~reset;

  // Echo-RAM pages E0-FF fold back onto C0-DF.
  assign rd_page = (src_page_q >= 8'hE0) ? (src_page_q & 8'hDF) : src_page_q;

  assign dma_active = active;

  always_comb begin
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    cpu_rdata = 8'hFF;
    if (cpu_wins) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_re    = cpu_re & ~cpu_we;
      mem_wdata = cpu_we ? cpu_wdata : 8'h00;
    end else if (dma_rd) begin
      mem_addr = {rd_page, idx_q};
      mem_re   = 1'b1;
    end else if (dma_wr) begin
      mem_addr  = OAM_BASE + {8'h00, idx_q};
      mem_wdata = latch_q;
      mem_we    = 1'b1;
    end
    if (reg_rd) begin
      cpu_rdata = src_page_q;
    end else if (cpu_wins && cpu_re && !cpu_we) begin
      cpu_rdata = mem_rdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    latch_d    = latch_q;
    src_page_d = src_page_q;
    if (reg_wr) begin
      src_page_d = cpu_wdata;
      state_d    = StStart;
      idx_d      = 8'h00;
    end else begin
      case (state_q)
        StStart: state_d = StRead;
        StRead: begin
          if (dma_rd) begin
            latch_d = mem_rdata;
            state_d = StWrite;
          end
        end
        StWrite: begin
          if (dma_wr) begin
            idx_d   = idx_q + 8'd1;
            state_d = (({1'b0, idx_q} + 9'd1) == LenCount) ? StIdle : StRead;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= 8'h00;
      latch_q    <= 8'h00;
      src_page_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      latch_q    <= latch_d;
      src_page_q <= src_page_d;
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Scoreboard bench for oam_dma_arbiter: a transaction-level model queues expected bus/CPU events.
// Define DMA_CPU_BLOCK_EN for both bench and RTL to exercise the blocking build.
module tb_oam_dma_arbiter;
  localparam int unsigned Len  = 160;
  localparam logic [15:0] RegA = 16'hFF46;
  localparam logic [15:0] Oam  = 16'hFE00;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = 16'h0;
  logic [7:0]  cpu_wdata = 8'h0;
  logic        cpu_we = 1'b0;
  logic        cpu_re = 1'b0;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;
  logic        dma_active;

  always #5 clock = ~clock;

  oam_dma_arbiter #(
    .DMA_REG_ADDR(RegA),
    .OAM_BASE    (Oam),
    .DMA_LEN     (Len)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_rdata (cpu_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .dma_active(dma_active)
  );

  // dmem is the memory the DUT talks to; rmem is the model's view of it.
  logic [7:0] dmem [65536];
  logic [7:0] rmem [65536];
  assign mem_rdata = dmem[mem_addr];
  always @(posedge clock) if (mem_we) dmem[mem_addr] <= mem_wdata;

  logic [23:0] q_dma [$];
  logic [23:0] q_cpuw [$];
  logic [7:0]  q_rd [$];
  int          q_len [$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] got);
    checks++;
    errors++;
    $display("FAIL %s: got event %0h expected none", name, got);
  endtask

  int run_len = 0;
  always @(negedge clock) begin
    logic [23:0] e;
    int l;
    check("we_re_exclusive", 32'(mem_we & mem_re), 32'd0);
    if (!mem_we && !mem_re) check("idle_bus", {8'h00, mem_addr, mem_wdata}, 32'd0);
    if (mem_we) begin
      if (mem_addr >= Oam && mem_addr < Oam + 16'(Len)) begin
        if (q_dma.size() == 0) unexpected("dma_write", {8'h00, mem_addr, mem_wdata});
        else begin
          e = q_dma.pop_front();
          check("dma_write", {8'h00, mem_addr, mem_wdata}, 32'(e));
        end
      end else begin
        if (q_cpuw.size() == 0) unexpected("cpu_write", {8'h00, mem_addr, mem_wdata});
        else begin
          e = q_cpuw.pop_front();
          check("cpu_write", {8'h00, mem_addr, mem_wdata}, 32'(e));
        end
      end
    end
    if (cpu_re) begin
      if (q_rd.size() == 0) unexpected("cpu_rdata", 32'(cpu_rdata));
      else check("cpu_rdata", 32'(cpu_rdata), 32'(q_rd.pop_front()));
    end
    if (dma_active) run_len++;
    else if (run_len != 0) begin
      if (q_len.size() == 0) unexpected("active_len", 32'(run_len));
      else begin
        l = q_len.pop_front();
        check("active_len", 32'(run_len), 32'(l));
      end
      run_len = 0;
    end
  end

  // Model: a transfer is one setup cycle then 2*Len free bus slots (read, write alternately).
  logic       m_active = 1'b0;
  logic       m_start = 1'b0;
  int         m_remain = 0;
  int         m_len = 0;
  logic [7:0] m_page = 8'h00;

  function automatic logic is_hram(input logic [15:0] a);
    return (a >= 16'hFF80) && (a <= 16'hFFFE);
  endfunction

  task automatic step(input logic rst, input logic we, input logic re, input logic [15:0] a,
                      input logic [7:0] d);
    logic wins;
    logic [7:0] pg, v;
    logic [15:0] src;
    int s, i;
    reset = rst; cpu_we = we; cpu_re = re; cpu_addr = a; cpu_wdata = d;
`ifdef DMA_CPU_BLOCK_EN
    wins = (we || re) && (a != RegA) && (!m_active || is_hram(a));
`else
    wins = (we || re) && (a != RegA);
`endif
    if (rst) begin
      if (m_active) q_len.push_back(m_len + 1);
      m_active = 1'b0; m_start = 1'b0; m_len = 0; m_page = 8'h00;
    end else begin
      if (re) q_rd.push_back(a == RegA ? m_page : (wins ? rmem[a] : 8'hFF));
      if (we && wins) begin
        rmem[a] = d;
        q_cpuw.push_back({a, d});
      end
      if (m_active) m_len++;
      if (we && a == RegA) begin
        m_page = d; m_active = 1'b1; m_start = 1'b1; m_remain = 2 * Len;
      end else if (m_active && m_start) begin
        m_start = 1'b0;
      end else if (m_active && !wins) begin
        s = 2 * Len - m_remain;
        if (s % 2 == 1) begin
          i = s / 2;
          pg = (m_page >= 8'hE0) ? m_page - 8'h20 : m_page;
          src = {pg, 8'(i)};
          v = rmem[src];
          rmem[Oam + 16'(i)] = v;
          q_dma.push_back({Oam + 16'(i), v});
        end
        m_remain--;
        if (m_remain == 0) begin
          q_len.push_back(m_len);
          m_len = 0;
          m_active = 1'b0;
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
  endtask

  task automatic run_to_done();
    int n = 0;
    while (m_active && n < 3000) begin
      step(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
      n++;
    end
    n = 0;
    while (dma_active && n < 20) begin
      step(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
      n++;
    end
    check("xfer_ends", 32'(dma_active), 32'd0);
  endtask

  initial begin
    logic [7:0] pg;
    int r;
    for (int a = 0; a < 65536; a++) begin
      dmem[a] = 8'($urandom);
      rmem[a] = dmem[a];
    end
    for (int i = 0; i < Len; i++) begin
      dmem[16'hC000 + i] = 8'(i) ^ 8'h5A;
      rmem[16'hC000 + i] = 8'(i) ^ 8'h5A;
    end
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    check("reset_active", 32'(dma_active), 32'd0);
    step(1'b0, 1'b0, 1'b1, RegA, 8'h0);

    // Plain transfer from C000.
    step(1'b0, 1'b1, 1'b0, RegA, 8'hC0);
    run_to_done();
    for (int i = 0; i < Len; i++) check("oam_c0", 32'(dmem[Oam + 16'(i)]), 32'(8'(i) ^ 8'h5A));

    // HRAM reads stolen on every cycle for a window.
    step(1'b0, 1'b1, 1'b0, RegA, 8'hC1);
    for (int k = 0; k < 40; k++) step(1'b0, 1'b0, 1'b1, 16'hFFA0, 8'h0);
    run_to_done();

    // Non-HRAM read and write mid-transfer.
    step(1'b0, 1'b1, 1'b0, RegA, 8'hC2);
    idle(20);
    step(1'b0, 1'b0, 1'b1, 16'hC000, 8'h0);
    step(1'b0, 1'b1, 1'b0, 16'hD000, 8'h11);
    run_to_done();
`ifdef DMA_CPU_BLOCK_EN
    check("d000_kept", 32'(dmem[16'hD000]), 32'(rmem[16'hD000]));
`else
    check("d000_written", 32'(dmem[16'hD000]), 32'h11);
`endif

    // Restart at idx 50.
    step(1'b0, 1'b1, 1'b0, RegA, 8'hC0);
    idle(1 + 2 * 50);
    step(1'b0, 1'b1, 1'b0, RegA, 8'hD0);
    run_to_done();
    step(1'b0, 1'b0, 1'b1, RegA, 8'h0);

    // Echo page F1 reads D1xx.
    step(1'b0, 1'b1, 1'b0, RegA, 8'hF1);
    run_to_done();
    for (int i = 0; i < Len; i += 37)
      check("oam_echo", 32'(dmem[Oam + 16'(i)]), 32'(dmem[16'hD100 + 16'(i)]));

    // Random CPU traffic over random transfers.
    for (int t = 0; t < 4; t++) begin
      r = $urandom_range(0, 63);
      pg = (r < 32) ? 8'hC0 + 8'(r) : 8'hE0 + 8'(r - 32);
      step(1'b0, 1'b1, 1'b0, RegA, pg);
      for (int k = 0; k < 1500 && m_active; k++) begin
        case ($urandom_range(0, 9))
          4: step(1'b0, 1'b0, 1'b1, 16'hFF80 + 16'($urandom_range(0, 126)), 8'h0);
          5: step(1'b0, 1'b1, 1'b0, 16'hFF80 + 16'($urandom_range(0, 126)), 8'($urandom));
          6: step(1'b0, 1'b0, 1'b1, 16'hC000 + 16'($urandom_range(0, 16'h1FFF)), 8'h0);
          7: step(1'b0, 1'b1, 1'b0, 16'h8000 + 16'($urandom_range(0, 255)), 8'($urandom));
          8: step(1'b0, 1'b0, 1'b1, RegA, 8'h0);
          9: begin
            step(1'b0, 1'b0, 1'b1, 16'hFF7F, 8'h0);
            step(1'b0, 1'b1, 1'b0, 16'hFFFF, 8'($urandom));
            step(1'b0, 1'b0, 1'b1, 16'hFFFF, 8'h0);
          end
          default: step(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        endcase
      end
      run_to_done();
    end

    // Reset at idx 80 aborts the copy.
    step(1'b0, 1'b1, 1'b0, RegA, 8'hC3);
    idle(1 + 2 * 80);
    step(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    check("abort_active", 32'(dma_active), 32'd0);
    idle(30);
    step(1'b0, 1'b0, 1'b1, RegA, 8'h0);
    idle(2);

    for (int i = 0; i < Len; i++)
      check("oam_final", 32'(dmem[Oam + 16'(i)]), 32'(rmem[Oam + 16'(i)]));
    check("d000_final", 32'(dmem[16'hD000]), 32'(rmem[16'hD000]));
    check("dma_q_drained", 32'(q_dma.size()), 32'd0);
    check("cpuw_q_drained", 32'(q_cpuw.size()), 32'd0);
    check("rd_q_drained", 32'(q_rd.size()), 32'd0);
    check("len_q_drained", 32'(q_len.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/oam_dma_arbiter.md
OAM_DMA_ARBITER -- requirements
Module: oam_dma_arbiter

Interface
REQ-001 SHALL have parameter DMA_REG_ADDR, default 16'hFF46, the CPU address of the DMA start/source register.
REQ-002 SHALL have parameter OAM_BASE, default 16'hFE00, the destination base address.
REQ-003 SHALL have parameter DMA_LEN, default 160, the bytes per transfer (1..256).
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have ports cpu_addr (input, 16), cpu_wdata (input, 8), cpu_we (input, 1) and cpu_re (input, 1): the CPU-side request.
REQ-007 SHALL have port cpu_rdata, output, 8 bits: read data returned to the CPU in the same cycle as cpu_re.
REQ-008 SHALL have ports mem_addr (output, 16), mem_wdata (output, 8), mem_we (output, 1) and mem_re (output, 1): the memory-side bus.
REQ-009 SHALL have port mem_rdata, input, 8 bits: memory read data, valid combinationally in the mem_re cycle.
REQ-010 SHALL have port dma_active, output, 1 bit: high while a transfer is in progress.

Function
REQ-011 SHALL implement FSM states IDLE, START, READ and WRITE, plus an 8-bit byte index idx and an 8-bit data latch.
REQ-012 In IDLE, every CPU access other than DMA_REG_ADDR SHALL pass combinationally through to mem_* (cpu_rdata = mem_rdata).
REQ-013 A CPU write to DMA_REG_ADDR SHALL latch src_page = cpu_wdata, never drive the memory side, and move the FSM to START with idx=0 from any state (restart).
REQ-014 If src_page >= 8'hE0, the page actually read SHALL be src_page & 8'hDF.
REQ-015 A CPU read of DMA_REG_ADDR SHALL return src_page and never assert mem_re, regardless of state.
REQ-016 START SHALL last exactly one cycle with no DMA bus use, then go to READ.
REQ-017 READ SHALL drive mem_re=1, mem_addr={page,idx}, latch mem_rdata, then go to WRITE.
REQ-018 WRITE SHALL drive mem_we=1, mem_addr=OAM_BASE+idx, mem_wdata=latch, then increment idx.
REQ-019 After WRITE, the FSM SHALL go to IDLE if idx+1 == DMA_LEN, otherwise to READ.
REQ-020 dma_active SHALL be 1 in START, READ and WRITE; a write to DMA_REG_ADDR in cycle N gives dma_active=1 from N+1.
REQ-021 With no stalls, dma_active SHALL stay high for exactly 1+2*DMA_LEN cycles (321 at the default DMA_LEN).
REQ-022 While dma_active, a CPU access to FF80-FFFE SHALL win the bus; that cycle the DMA step SHALL stall with state, idx and latch held.
REQ-023 While dma_active, CPU accesses outside FF80-FFFE SHALL follow the Configuration section.
REQ-024 mem_we and mem_re SHALL never be asserted in the same cycle.
REQ-025 When no party uses the bus, mem_we=0, mem_re=0, mem_addr=0 and mem_wdata=0.
REQ-026 When nothing drives it, cpu_rdata SHALL be 8'hFF.

Reset
REQ-027 On reset, the FSM SHALL go to IDLE with idx=0, latch=0, src_page=0 and dma_active=0, and all mem_* outputs low on the following cycle.
REQ-028 Reset mid-transfer SHALL abort the transfer and issue no further DMA bus cycles.

Configuration
REQ-029 The macro DMA_CPU_BLOCK_EN SHALL select how non-HRAM CPU accesses are handled while dma_active.
REQ-030 With DMA_CPU_BLOCK_EN defined, such reads SHALL return 8'hFF and such writes SHALL be dropped, with no memory access; the DMA never stalls for them.
REQ-031 Without DMA_CPU_BLOCK_EN, all CPU accesses SHALL have bus priority (cycle stealing) and the DMA SHALL stall in those cycles as in REQ-022.

Verification
REQ-032 Scenario: memory C000-C09F = i^8'h5A; CPU writes 8'hC0 to FF46 -> FE00+i == i^8'h5A for i=0..159, dma_active high exactly 321 cycles.
REQ-033 Scenario: CPU reads FFA0 on every cycle of a transfer -> each read returns HRAM data and transfer completion is delayed by the number of READ/WRITE cycles stolen.
REQ-034 Scenario: with DMA_CPU_BLOCK_EN defined, CPU reads C000 and writes 8'h11 to D000 mid-DMA -> read returns 8'hFF and D000 is unchanged; without the macro -> real data is returned, D000 == 8'h11, and the DMA takes 2 extra cycles.
REQ-035 Scenario: write 8'hC0 to FF46, then 8'hD0 at idx 50 -> FE00-FE31 hold C0xx data, FE00-FE9F are rewritten from D000, and FF46 reads 8'hD0.
REQ-036 Scenario: write 8'hF1 to FF46 -> the source read is D100-D19F.
REQ-037 Scenario: reset asserted at idx 80 -> dma_active=0 next cycle, no mem_we afterwards, and FE50-FE9F are untouched.
